// File: rtl/logic_op_dispatch_pkg.sv
// logic_op_dispatch_pkg: opcodes, FSM encodings and default lane width shared by the dispatch block.
package logic_op_dispatch_pkg;
    localparam int DEF_WIDTH = 8;
    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
endpackage

// File: rtl/logic_op_dispatch_if.sv
// logic_op_dispatch_if: operand handshake plus four-lane result bus; LANE_PARITY_EN adds lane_par.
interface logic_op_dispatch_if
    import logic_op_dispatch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] orr_o;
    logic [WIDTH-1:0] xorr_o;
    logic [WIDTH-1:0] norr_o;
    logic [WIDTH-1:0] xnorr_o;
    logic             lane_vld;
    logic             lane_ack;
    logic [CNT_W-1:0] op_count;
`ifdef LANE_PARITY_EN
    logic             lane_par;
`endif
    modport slave (
        input  in_valid, op_a, op_b, op_sel, lane_ack,
        output in_ready, orr_o, xorr_o, norr_o, xnorr_o, lane_vld, op_count
`ifdef LANE_PARITY_EN
        , lane_par
`endif
    );
    modport master (
        output in_valid, op_a, op_b, op_sel, lane_ack,
        input  in_ready, orr_o, xorr_o, norr_o, xnorr_o, lane_vld, op_count
`ifdef LANE_PARITY_EN
        , lane_par
`endif
    );
endinterface

// File: rtl/logic_op_dispatch_unit.sv
// logic_op_unit: combinational bitwise op; the result appears on the lane chosen by sel, others zero.
module logic_op_unit
    import logic_op_dispatch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] orr,
    output logic [WIDTH-1:0] xorr,
    output logic [WIDTH-1:0] norr,
    output logic [WIDTH-1:0] xnorr
);
    always_comb begin
        orr   = (sel == OP_OR)   ? (a | b)    : '0;
        xorr  = (sel == OP_XOR)  ? (a ^ b)    : '0;
        norr  = (sel == OP_NOR)  ? ~(a | b)   : '0;
        xnorr = (sel == OP_XNOR) ? ~(a ^ b)   : '0;
    end
endmodule

// File: rtl/logic_op_dispatch.sv
// logic_op_dispatch: captures an op, registers its one-hot lane result, holds it until ack, counts completions.
// Optional LANE_PARITY_EN adds lane_par, the XOR-reduce of the active lane.
module logic_op_dispatch
    import logic_op_dispatch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    logic_op_dispatch_if.slave bus
);
    logic [1:0]       st_q, st_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] orr_q, orr_d, xorr_q, xorr_d, norr_q, norr_d, xnorr_q, xnorr_d;
    logic [WIDTH-1:0] u_orr, u_xorr, u_norr, u_xnorr;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take, exec, done;
`ifdef LANE_PARITY_EN
    logic             par_q, par_d;
`endif

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .a(a_q), .b(b_q), .sel(sel_q),
        .orr(u_orr), .xorr(u_xorr), .norr(u_norr), .xnorr(u_xnorr)
    );

    always_comb begin
        take    = (st_q == ST_IDLE) && bus.in_valid;
        exec    = (st_q == ST_EXEC);
        done    = (st_q == ST_HOLD) && bus.lane_ack;
        st_d    = take ? ST_EXEC : exec ? ST_HOLD : done ? ST_IDLE :
                  (st_q == ST_HOLD) ? ST_HOLD : ST_IDLE;
        a_d     = take ? bus.op_a : a_q;
        b_d     = take ? bus.op_b : b_q;
        sel_d   = take ? bus.op_sel : sel_q;
        orr_d   = exec ? u_orr   : done ? '0 : orr_q;
        xorr_d  = exec ? u_xorr  : done ? '0 : xorr_q;
        norr_d  = exec ? u_norr  : done ? '0 : norr_q;
        xnorr_d = exec ? u_xnorr : done ? '0 : xnorr_q;
        vld_d   = exec ? 1'b1 : done ? 1'b0 : vld_q;
        cnt_d   = cnt_q + CNT_W'(done);
`ifdef LANE_PARITY_EN
        // unit lanes are one-hot, so OR-ing them yields the active result
        par_d   = exec ? ^(u_orr | u_xorr | u_norr | u_xnorr) : done ? 1'b0 : par_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= OP_OR;
            orr_q   <= '0;
            xorr_q  <= '0;
            norr_q  <= '0;
            xnorr_q <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            orr_q   <= orr_d;
            xorr_q  <= xorr_d;
            norr_q  <= norr_d;
            xnorr_q <= xnorr_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LANE_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
    assign bus.lane_par = par_q;
`endif

    assign bus.in_ready = (st_q == ST_IDLE);
    assign bus.orr_o    = orr_q;
    assign bus.xorr_o   = xorr_q;
    assign bus.norr_o   = norr_q;
    assign bus.xnorr_o  = xnorr_q;
    assign bus.lane_vld = vld_q;
    assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_logic_op_dispatch.sv
// tb_logic_op_dispatch: directed vectors checked against a transaction-level model every cycle.
module tb_logic_op_dispatch;
    localparam int W  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_op_dispatch_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    logic_op_dispatch #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    logic          m_busy, m_vld;
    logic [1:0]    m_sel;
    logic [W-1:0]  m_res;
    logic [CW-1:0] m_cnt;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return a | b;
            2'd1:    return a ^ b;
            2'd2:    return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic [W-1:0] lane_of(input logic [1:0] s);
        case (s)
            2'd0:    return bus.orr_o;
            2'd1:    return bus.xorr_o;
            2'd2:    return bus.norr_o;
            default: return bus.xnorr_o;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one outstanding op at a time: accepted, then visible one edge later, until acked
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_vld <= 1'b0; m_sel <= 2'd0; m_res <= '0; m_cnt <= '0;
        end else if (m_vld && bus.lane_ack) begin
            m_busy <= 1'b0; m_vld <= 1'b0; m_cnt <= m_cnt + 1'b1;
        end else if (m_busy) begin
            m_vld <= 1'b1;
        end else if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_res  <= ref_op(bus.op_a, bus.op_b, bus.op_sel);
            m_sel  <= bus.op_sel;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc in_ready", 32'(bus.in_ready), 32'(!m_busy));
            chk("cyc lane_vld", 32'(bus.lane_vld), 32'(m_vld));
            chk("cyc orr_o",   32'(bus.orr_o),   (m_vld && m_sel == 2'd0) ? 32'(m_res) : 32'd0);
            chk("cyc xorr_o",  32'(bus.xorr_o),  (m_vld && m_sel == 2'd1) ? 32'(m_res) : 32'd0);
            chk("cyc norr_o",  32'(bus.norr_o),  (m_vld && m_sel == 2'd2) ? 32'(m_res) : 32'd0);
            chk("cyc xnorr_o", 32'(bus.xnorr_o), (m_vld && m_sel == 2'd3) ? 32'(m_res) : 32'd0);
            chk("cyc op_count", 32'(bus.op_count), 32'(m_cnt));
`ifdef LANE_PARITY_EN
            chk("cyc lane_par", 32'(bus.lane_par), m_vld ? 32'(^m_res) : 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        int k = 0;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!bus.in_ready) chk("issue ready timeout", 32'(bus.in_ready), 32'd1);
        bus.op_a = a; bus.op_b = b; bus.op_sel = s; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("lat vld at N", 32'(bus.lane_vld), 32'd0);
        tick();
        chk("lat vld at N+1", 32'(bus.lane_vld), 32'd1);
    endtask

    task automatic ack();
        bus.lane_ack = 1'b1;
        tick();
        bus.lane_ack = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp2 [4];
        exp2[0] = 8'hFC; exp2[1] = 8'hCC; exp2[2] = 8'h03; exp2[3] = 8'h33;
        bus.in_valid = 1'b0; bus.lane_ack = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.op_sel = 2'd0;
        @(posedge clk);
        chk_en = 1'b1;
        tick();
        chk("rst lanes", 32'(bus.orr_o | bus.xorr_o | bus.norr_o | bus.xnorr_o), 32'd0);
        chk("rst lane_vld", 32'(bus.lane_vld), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst op_count", 32'(bus.op_count), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int s = 0; s < 4; s++) begin
            issue(8'hF0, 8'h3C, 2'(s));
            chk("op F0/3C lane", 32'(lane_of(2'(s))), 32'(exp2[s]));
            chk("op F0/3C other lanes",
                32'((bus.orr_o | bus.xorr_o | bus.norr_o | bus.xnorr_o) ^ lane_of(2'(s))), 32'd0);
            ack();
            chk("op_count after ack", 32'(bus.op_count), 32'(s + 1));
        end

        issue(8'hAA, 8'h55, 2'd0);
        for (int i = 0; i < 10; i++) begin
            bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
            bus.op_sel = 2'(i); bus.in_valid = i[0];
            tick();
            chk("hold orr_o", 32'(bus.orr_o), 32'hFF);
            chk("hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        ack();
        chk("hold op_count", 32'(bus.op_count), 32'd5);
        chk("hold back to idle", 32'(bus.in_ready), 32'd1);

        bus.lane_ack = 1'b1;
        tick();
        bus.lane_ack = 1'b0;
        chk("idle ack ignored", 32'(bus.op_count), 32'd5);

        issue(8'hF0, 8'h3C, 2'd3);
        chk("pre-rst xnorr_o", 32'(bus.xnorr_o), 32'h33);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid-hold rst xnorr_o", 32'(bus.xnorr_o), 32'd0);
        chk("mid-hold rst lane_vld", 32'(bus.lane_vld), 32'd0);
        chk("mid-hold rst op_count", 32'(bus.op_count), 32'd0);

        for (int i = 0; i < 255; i++) begin
            issue(8'(i), 8'(~i), 2'(i));
            ack();
        end
        chk("wrap count FF", 32'(bus.op_count), 32'hFF);
        issue(8'h07, 8'h00, 2'd0);
        chk("orr 07", 32'(bus.orr_o), 32'h07);
`ifdef LANE_PARITY_EN
        chk("lane_par 07", 32'(bus.lane_par), 32'd1);
`endif
        ack();
        chk("wrap count 00", 32'(bus.op_count), 32'h00);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
